// File: rtl/multicycle_ctrl_if.sv
// Datapath control bundle between the multi-cycle sequencer and the RV32 datapath/memory.
// master = sequencer side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        eq;
  logic        mem_ready;
  logic        ir_we;
  logic        pc_we;
  logic        pc_src;
  logic        adr_src;
  logic        mem_re;
  logic        mem_we;
  logic        reg_we;
  logic        result_src;
  logic        alu_src;
  logic [2:0]  alu_ctrl;
  logic [1:0]  imm_src;

  modport master (
    input  instr, eq, mem_ready,
    output ir_we, pc_we, pc_src, adr_src, mem_re, mem_we, reg_we,
           result_src, alu_src, alu_ctrl, imm_src
  );

  modport slave (
    output instr, eq, mem_ready,
    input  ir_we, pc_we, pc_src, adr_src, mem_re, mem_we, reg_we,
           result_src, alu_src, alu_ctrl, imm_src
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control sequencer: fetch/decode/execute/memory/writeback with
// ready-handshake memory, retired-instruction counter and sticky trap on illegal encodings.
//
// state  | meaning
// IDLE   | parked, waiting for run
// FETCH  | reading instruction at PC, held until mem_ready
// DECODE | instruction register valid, legality check
// EXEC   | ALU operation; branches resolve and complete here
// MEM    | load/store access at ALU result, held until mem_ready
// WB     | register write-back, PC+4, completes
// HALT   | illegal encoding trapped, left only by reset
module multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  multicycle_ctrl_if.master    bus,
  output logic                 busy,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t state;
  state_t state_next;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_addi, is_add, is_sub, is_lw, is_sw, is_beq, is_bne;
  logic       is_legal;
  logic       done;
  logic       unused_instr_bits;

  logic       ir_we, pc_we, pc_src, adr_src, mem_re, mem_we, reg_we;
  logic       result_src, alu_src;
  logic [2:0] alu_ctrl;
  logic [1:0] imm_src;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign unused_instr_bits = ^{bus.instr[24:15], bus.instr[11:7]};

  assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign is_legal = is_addi | is_add | is_sub | is_lw | is_sw | is_beq | is_bne;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    busy       = 1'b0;
    illegal    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    adr_src    = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    result_src = 1'b0;
    alu_src    = 1'b0;
    alu_ctrl   = 3'b000;
    imm_src    = 2'b00;

    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        busy   = 1'b1;
        mem_re = 1'b1;
        if (bus.mem_ready) begin
          ir_we      = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        busy       = 1'b1;
        state_next = is_legal ? EXEC : HALT;
      end
      EXEC: begin
        busy = 1'b1;
        if (is_add || is_sub) begin
          alu_ctrl   = is_sub ? 3'b001 : 3'b000;
          state_next = WB;
        end else if (is_addi) begin
          alu_src    = 1'b1;
          state_next = WB;
        end else if (is_lw || is_sw) begin
          alu_src    = 1'b1;
          imm_src    = is_sw ? 2'b01 : 2'b00;
          state_next = MEM;
        end else if (is_beq || is_bne) begin
          alu_ctrl = 3'b001;
          imm_src  = 2'b10;
          pc_we    = 1'b1;
          pc_src   = is_beq ? bus.eq : ~bus.eq;
          done     = 1'b1;
        end else begin
          // instr changed after DECODE; trap rather than guess
          state_next = HALT;
        end
      end
      MEM: begin
        busy    = 1'b1;
        adr_src = 1'b1;
        mem_re  = is_lw;
        mem_we  = is_sw;
        if (bus.mem_ready) begin
          if (is_lw) begin
            state_next = WB;
          end else begin
            pc_we = 1'b1;
            done  = 1'b1;
          end
        end
      end
      WB: begin
        busy       = 1'b1;
        reg_we     = 1'b1;
        result_src = is_lw;
        pc_we      = 1'b1;
        done       = 1'b1;
      end
      HALT: begin
        illegal = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (done) state_next = run ? FETCH : IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret <= '0;
    end else if (done) begin
      instret <= instret + CNT_WIDTH'(1);
    end
  end

  assign bus.ir_we      = ir_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_src     = pc_src;
  assign bus.adr_src    = adr_src;
  assign bus.mem_re     = mem_re;
  assign bus.mem_we     = mem_we;
  assign bus.reg_we     = reg_we;
  assign bus.result_src = result_src;
  assign bus.alu_src    = alu_src;
  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.imm_src    = imm_src;

endmodule
